// File: rtl/lbcf_comb_filter.sv
// Lowpass-feedback comb filter: one sample per pass through a delay RAM, with a
// one-pole damping store (fs) in the feedback path and saturating write-back.
module lbcf_comb_filter #(
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 24,
    parameter int DELAY_LEN = 1116,
    parameter int ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [COEF_W-1:0] decay_value,
    input  logic [COEF_W-1:0] damping_value,
    output logic              clear_busy
);

    localparam int PROD_W = DATA_W + COEF_W + 3;
    localparam int SUM_W  = DATA_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DELAY_LEN - 1);
    localparam logic [COEF_W:0]   COEF_ONE  = {1'b1, {COEF_W{1'b0}}};
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_CALC  = 3'd3,
        ST_WRITE = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    state_t                    state_r;
    logic [ADDR_W-1:0]         clr_addr_r;
    logic [ADDR_W-1:0]         ptr_r;
    logic signed [DATA_W-1:0]  fs_r;
    logic signed [DATA_W-1:0]  x_r;
    logic signed [DATA_W-1:0]  y_r;
    logic [COEF_W-1:0]         g_r;
    logic [COEF_W-1:0]         d_r;
    logic                      in_ready_r;
    logic                      out_valid_r;
    logic [DATA_W-1:0]         out_data_r;
    logic                      clear_busy_r;

    logic [DATA_W-1:0]         mem_r [DELAY_LEN];
    logic [DATA_W-1:0]         ram_rdata_r;
    logic                      ram_we_s;
    logic [ADDR_W-1:0]         ram_addr_s;
    logic [DATA_W-1:0]         ram_wdata_s;

    // Clamp a widened sum into the signed DATA_W range.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        if (v > SUM_W'(SAT_MAX)) begin
            return SAT_MAX;
        end else if (v < SUM_W'(SAT_MIN)) begin
            return SAT_MIN;
        end else begin
            return DATA_W'(v);
        end
    endfunction

    // fs_next = floor((y*(1-d) + fs*d)), a convex mix so it always fits DATA_W.
    function automatic logic signed [DATA_W-1:0] damp_step(
        input logic signed [DATA_W-1:0] y,
        input logic signed [DATA_W-1:0] fs,
        input logic [COEF_W-1:0]        d
    );
        logic signed [COEF_W+1:0] wy_s;
        logic signed [COEF_W+1:0] wf_s;
        logic signed [PROD_W-1:0] acc_s;
        wy_s  = $signed({1'b0, COEF_ONE - {1'b0, d}});
        wf_s  = $signed({2'b00, d});
        acc_s = PROD_W'(y) * PROD_W'(wy_s) + PROD_W'(fs) * PROD_W'(wf_s);
        return DATA_W'(acc_s >>> COEF_W);
    endfunction

    // Write-back value: x + floor(fs*g), summed wide then saturated.
    function automatic logic signed [DATA_W-1:0] feed_sum(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] fs,
        input logic [COEF_W-1:0]        g
    );
        logic signed [PROD_W-1:0] prod_s;
        logic signed [SUM_W-1:0]  sum_s;
        prod_s = PROD_W'(fs) * PROD_W'($signed({1'b0, g}));
        sum_s  = SUM_W'(x) + SUM_W'(prod_s >>> COEF_W);
        return sat(sum_s);
    endfunction

    // RAM port steering; writes are suppressed on a reset edge so an aborted sample never lands.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = ptr_r;
        ram_wdata_s = {DATA_W{1'b0}};
        case (state_r)
            ST_CLEAR: begin
                ram_we_s    = ~reset;
                ram_addr_s  = clr_addr_r;
                ram_wdata_s = {DATA_W{1'b0}};
            end
            ST_WRITE: begin
                ram_we_s    = ~reset;
                ram_addr_s  = ptr_r;
                ram_wdata_s = feed_sum(x_r, fs_r, g_r);
            end
            default: begin
                ram_we_s    = 1'b0;
                ram_addr_s  = ptr_r;
                ram_wdata_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Single-port delay RAM with registered read; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[ram_addr_s] <= ram_wdata_s;
        end
        ram_rdata_r <= mem_r[ram_addr_s];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_CLEAR;
            clr_addr_r   <= {ADDR_W{1'b0}};
            ptr_r        <= {ADDR_W{1'b0}};
            fs_r         <= {DATA_W{1'b0}};
            x_r          <= {DATA_W{1'b0}};
            y_r          <= {DATA_W{1'b0}};
            g_r          <= {COEF_W{1'b0}};
            d_r          <= {COEF_W{1'b0}};
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
            clear_busy_r <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_addr_r == LAST_ADDR) begin
                        clr_addr_r   <= {ADDR_W{1'b0}};
                        clear_busy_r <= 1'b0;
                        in_ready_r   <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        clr_addr_r <= clr_addr_r + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        x_r        <= in_data;
                        g_r        <= decay_value;
                        d_r        <= damping_value;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_READ;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_READ: begin
                    state_r <= ST_CALC;
                end
                ST_CALC: begin
                    y_r     <= ram_rdata_r;
                    fs_r    <= damp_step(ram_rdata_r, fs_r, d_r);
                    state_r <= ST_WRITE;
                end
                ST_WRITE: begin
                    out_data_r  <= y_r;
                    out_valid_r <= 1'b1;
                    ptr_r       <= (ptr_r == LAST_ADDR) ? {ADDR_W{1'b0}} : ptr_r + ADDR_W'(1);
                    state_r     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    clr_addr_r   <= {ADDR_W{1'b0}};
                    in_ready_r   <= 1'b0;
                    out_valid_r  <= 1'b0;
                    clear_busy_r <= 1'b1;
                    state_r      <= ST_CLEAR;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign clear_busy = clear_busy_r;

endmodule
